spi_register_master: RTL

//  Host-side SPI initiator for the synth register interface; the transmitting end of the synth SPI slave.

---
 rtl/spi_register_master_pkg.sv | 27 ++
 rtl/spi_register_master_fifo.sv | 53 +++++
 rtl/spi_register_master.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/spi_register_master_pkg.sv
// Shared definitions for the synth SPI register interface: frame layout,
// register-number fields, parameter codes and the queued write request type.
package spi_register_master_pkg;

    localparam int SPI_FRAME_BITS = 32;
    localparam int SPI_WRITE_FLAG = 31;

    localparam int REG_PARAM_W  = 7;
    localparam int REG_INDEX_W  = 8;
    localparam int REG_NUMBER_W = REG_PARAM_W + REG_INDEX_W;
    localparam int REG_VALUE_W  = 16;

    localparam logic [5:0] VOICE_OP_PARAM_FIRST = 6'h00;
    localparam logic [5:0] VOICE_OP_PARAM_LAST  = 6'h06;
    localparam logic [5:0] GLOBAL_PARAM_FIRST   = 6'h00;
    localparam logic [5:0] GLOBAL_PARAM_LAST    = 6'h01;

    typedef struct packed {
        logic [REG_NUMBER_W-1:0] number;
        logic [REG_VALUE_W-1:0]  value;
    } reg_write_t;

    function automatic logic [SPI_FRAME_BITS-1:0] frame_word(input reg_write_t w);
        return {1'b1, w.number, w.value};
    endfunction

endpackage

// File: rtl/spi_register_master_fifo.sv
// Synchronous write-request queue; data storage is not reset, only pointers and count.
module spi_cmd_fifo
    import spi_register_master_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Push,
    input  reg_write_t               i_Data,
    input  logic                     i_Pop,
    output reg_write_t               o_Data,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [$clog2(DEPTH):0]   o_Count
);
    localparam int AW = $clog2(DEPTH);

    reg_write_t        mem [DEPTH];
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtr;
    logic [AW:0]       count;
    logic              doPush;
    logic              doPop;

    assign doPush  = i_Push && !o_Full;
    assign doPop   = i_Pop && !o_Empty;
    assign o_Full  = (count == (AW+1)'(DEPTH));
    assign o_Empty = (count == '0);
    assign o_Count = count;
    assign o_Data  = mem[rdPtr];

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (doPush) mem[wrPtr] <= i_Data;
    end

endmodule

// File: rtl/spi_register_master.sv
// Host-side SPI mode-0 initiator: serializes queued register writes as 32-bit
// MSB-first frames and captures the synth's 16-bit sample from MISO.
module spi_register_master
    import spi_register_master_pkg::*;
#(
    parameter int CLKS_PER_HALF_SCK = 4,
    parameter int FRAME_GAP_CLKS    = 8,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    input  logic                    i_WriteValid,
    output logic                    o_WriteReady,
    input  logic [REG_NUMBER_W-1:0] i_WriteNumber,
    input  logic [REG_VALUE_W-1:0]  i_WriteValue,
    output logic                    o_Busy,
    output logic                    o_SampleValid,
    output logic signed [15:0]      o_Sample,
    output logic                    o_SPI_SCK,
    output logic                    o_SPI_MOSI,
    input  logic                    i_SPI_MISO,
    output logic                    o_SPI_CS_N
);
    localparam int HW = $clog2(CLKS_PER_HALF_SCK + 1);
    localparam int GW = $clog2(FRAME_GAP_CLKS + 1);

    localparam logic [1:0] StateIdle  = 2'd0;
    localparam logic [1:0] StateLoad  = 2'd1;
    localparam logic [1:0] StateShift = 2'd2;
    localparam logic [1:0] StateGap   = 2'd3;

    localparam logic [5:0]    LastBit    = 6'(SPI_FRAME_BITS - 1);
    localparam logic [HW-1:0] HalfReload = HW'(CLKS_PER_HALF_SCK - 1);

    logic [1:0]                 state;
    logic [HW-1:0]              halfCnt;
    logic [GW-1:0]              gapCnt;
    logic [5:0]                 bitCnt;
    logic [SPI_FRAME_BITS-1:0]  txShift;
    logic [SPI_FRAME_BITS-1:0]  rxShift;
    logic                       readyEn;
    logic                       sck;
    logic                       mosi;
    logic                       csN;
    logic                       sampleValid;
    logic signed [15:0]         sample;

    reg_write_t                 fifoData;
    logic                       fifoFull;
    logic                       fifoEmpty;
    logic [$clog2(FIFO_DEPTH):0] fifoCount;

    logic pushEn, popEn, halfDone, riseEn, fallEn;

    assign o_WriteReady  = readyEn && !fifoFull;
    assign pushEn        = i_WriteValid && o_WriteReady;
    assign o_Busy        = (fifoCount != '0) || (state != StateIdle);
    assign o_SampleValid = sampleValid;
    assign o_Sample      = sample;
    assign o_SPI_SCK     = sck;
    assign o_SPI_MOSI    = mosi;
    assign o_SPI_CS_N    = csN;

    spi_cmd_fifo #(.DEPTH(FIFO_DEPTH)) cmdFifo (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Push  (pushEn),
        .i_Data  ({i_WriteNumber, i_WriteValue}),
        .i_Pop   (popEn),
        .o_Data  (fifoData),
        .o_Full  (fifoFull),
        .o_Empty (fifoEmpty),
        .o_Count (fifoCount)
    );

    always_comb begin
        halfDone = (halfCnt == '0);
        popEn    = (state == StateIdle) && !fifoEmpty;
        riseEn   = halfDone && ((state == StateLoad) ||
                   ((state == StateShift) && !sck && (bitCnt != LastBit)));
        fallEn   = halfDone && (state == StateShift) && sck;
    end

    // Shift registers: tx loads on pop and advances on SCK fall; rx samples MISO on SCK rise
    always_ff @(posedge i_Clock) begin
        if (popEn)       txShift <= frame_word(fifoData);
        else if (fallEn) txShift <= {txShift[SPI_FRAME_BITS-2:0], 1'b0};
        if (riseEn)      rxShift <= {rxShift[SPI_FRAME_BITS-2:0], i_SPI_MISO};
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= StateIdle;
            halfCnt     <= '0;
            gapCnt      <= '0;
            bitCnt      <= '0;
            readyEn     <= 1'b0;
            sck         <= 1'b0;
            mosi        <= 1'b0;
            csN         <= 1'b1;
            sampleValid <= 1'b0;
            sample      <= '0;
        end else begin
            readyEn     <= 1'b1;
            sampleValid <= 1'b0;
            case (state)
                StateIdle: begin
                    if (popEn) begin
                        state   <= StateLoad;
                        halfCnt <= HW'(CLKS_PER_HALF_SCK);
                    end
                end
                StateLoad: begin
                    csN    <= 1'b0;
                    mosi   <= txShift[SPI_FRAME_BITS-1];
                    bitCnt <= '0;
                    if (halfDone) begin
                        sck     <= 1'b1;
                        halfCnt <= HalfReload;
                        state   <= StateShift;
                    end else begin
                        halfCnt <= halfCnt - HW'(1);
                    end
                end
                StateShift: begin
                    if (!halfDone) begin
                        halfCnt <= halfCnt - HW'(1);
                    end else if (sck) begin
                        sck     <= 1'b0;
                        mosi    <= txShift[SPI_FRAME_BITS-2];
                        halfCnt <= HalfReload;
                    end else if (bitCnt == LastBit) begin
                        // Low half of the last bit ends the frame
                        csN         <= 1'b1;
                        mosi        <= 1'b0;
                        sampleValid <= 1'b1;
                        sample      <= $signed(rxShift[SPI_FRAME_BITS-1:SPI_FRAME_BITS-16]);
                        gapCnt      <= GW'(FRAME_GAP_CLKS - 1);
                        state       <= StateGap;
                    end else begin
                        sck     <= 1'b1;
                        bitCnt  <= bitCnt + 6'd1;
                        halfCnt <= HalfReload;
                    end
                end
                default: begin
                    if (gapCnt == '0) state <= StateIdle;
                    else              gapCnt <= gapCnt - GW'(1);
                end
            endcase
        end
    end

endmodule
